// File: rtl/auto_player.sv
// auto_player: song-memory sequencer with start/stop/pause, loop and end marker.
// Define AUTO_PLAYER_TEMPO_EN to enable tempo_sel duration scaling.
module auto_player #(
    parameter int DEPTH      = 26,
    parameter int ADDR_W     = 5,
    parameter int NOTE_W     = 4,
    parameter int DUR_W      = 28,
    parameter int GAP_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [1:0]        tempo_sel,
    input  logic [NOTE_W-1:0] note_value,
    input  logic [DUR_W-1:0]  duration_value,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              key_on,
    output logic [NOTE_W-1:0] key,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LATCH  = 3'd2;
    localparam logic [2:0] S_NOTE   = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;
    localparam logic [2:0] S_PAUSED = 3'd5;

    localparam logic [DUR_W-1:0]  GAP_LAST  = DUR_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [2:0]        state, state_n;
    logic [2:0]        saved, saved_n;
    logic [DUR_W-1:0]  cnt, cnt_n;
    logic [DUR_W-1:0]  dur_r, dur_n;
    logic              loop_r, loop_n;
    logic [ADDR_W-1:0] addr_n;
    logic [NOTE_W-1:0] key_n;
    logic              key_on_n;
    logic              done_n;
    logic [DUR_W-1:0]  scaled;

`ifdef AUTO_PLAYER_TEMPO_EN
    localparam logic [DUR_W:0] DUR_MAX = {1'b0, {DUR_W{1'b1}}};
    logic [DUR_W:0] wide;

    always_comb begin
        wide = {1'b0, duration_value};
        case (tempo_sel)
            2'b01:   wide = {duration_value, 1'b0};
            2'b10:   wide = {1'b0, duration_value} >> 1;
            2'b11:   wide = {1'b0, duration_value} >> 2;
            default: wide = {1'b0, duration_value};
        endcase
        if (wide > DUR_MAX) begin
            wide = DUR_MAX;
        end else if (wide == '0) begin
            wide = (DUR_W+1)'(1);
        end
        scaled = wide[DUR_W-1:0];
    end
`else
    logic unused_tempo;
    assign unused_tempo = ^tempo_sel;
    assign scaled = duration_value;
`endif

    always_comb begin
        state_n  = state;
        saved_n  = saved;
        cnt_n    = cnt;
        dur_n    = dur_r;
        loop_n   = loop_r;
        addr_n   = mem_addr;
        key_n    = key;
        key_on_n = 1'b0;
        done_n   = 1'b0;
        if (stop) begin
            state_n = S_IDLE;
            addr_n  = '0;
            key_n   = '0;
            cnt_n   = '0;
        end else if (start) begin
            state_n = S_FETCH;
            addr_n  = '0;
            key_n   = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    addr_n = '0;
                    key_n  = '0;
                end
                S_FETCH: state_n = S_LATCH;
                S_LATCH: begin
                    loop_n = loop_en;
                    if (duration_value == '0) begin
                        // a marker at address 0 would loop forever on an empty song
                        if (loop_en && mem_addr != '0) begin
                            state_n = S_FETCH;
                            addr_n  = '0;
                        end else begin
                            state_n = S_IDLE;
                            addr_n  = '0;
                            key_n   = '0;
                            done_n  = 1'b1;
                        end
                    end else begin
                        state_n  = S_NOTE;
                        cnt_n    = '0;
                        dur_n    = scaled;
                        key_n    = note_value;
                        key_on_n = (note_value != '0);
                    end
                end
                S_NOTE: begin
                    if (cnt == dur_r - 1'b1) begin
                        state_n = S_GAP;
                        cnt_n   = '0;
                    end else begin
                        cnt_n    = cnt + 1'b1;
                        key_on_n = (key != '0);
                    end
                    // the cycle that sees pause was already played, so it counts
                    if (pause) begin
                        saved_n  = state_n;
                        state_n  = S_PAUSED;
                        key_on_n = 1'b0;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt_n = '0;
                        if (mem_addr == LAST_ADDR) begin
                            addr_n = '0;
                            if (loop_r) begin
                                state_n = S_FETCH;
                            end else begin
                                state_n = S_IDLE;
                                key_n   = '0;
                                done_n  = 1'b1;
                            end
                        end else begin
                            state_n = S_FETCH;
                            addr_n  = mem_addr + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                        if (pause) begin
                            saved_n = S_GAP;
                            state_n = S_PAUSED;
                        end
                    end
                end
                S_PAUSED: begin
                    if (!pause) begin
                        state_n  = saved;
                        key_on_n = (saved == S_NOTE) && (key != '0);
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    addr_n  = '0;
                    key_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            saved    <= S_NOTE;
            cnt      <= '0;
            dur_r    <= '0;
            loop_r   <= 1'b0;
            mem_addr <= '0;
            key      <= '0;
            key_on   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            saved    <= saved_n;
            cnt      <= cnt_n;
            dur_r    <= dur_n;
            loop_r   <= loop_n;
            mem_addr <= addr_n;
            key      <= key_n;
            key_on   <= key_on_n;
            busy     <= (state_n != S_IDLE);
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_auto_player.sv
// tb_auto_player: directed checks of auto_player with DEPTH=4, GAP_CYCLES=3.
// Memory is modelled as a registered read of two small arrays.
module tb_auto_player;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int NOTE_W = 4;
    localparam int DUR_W  = 8;
    localparam int GAP    = 3;
    localparam int N      = 48;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              pause = 1'b0;
    logic              loop_en = 1'b0;
    logic [1:0]        tempo_sel = 2'b00;
    logic [NOTE_W-1:0] note_value;
    logic [DUR_W-1:0]  duration_value;
    logic [ADDR_W-1:0] mem_addr;
    logic              key_on;
    logic [NOTE_W-1:0] key;
    logic              busy;
    logic              done;

    logic [NOTE_W-1:0] mem_note [0:DEPTH-1];
    logic [DUR_W-1:0]  mem_dur  [0:DEPTH-1];

    logic              t_kon  [0:N-1];
    logic [NOTE_W-1:0] t_key  [0:N-1];
    logic [ADDR_W-1:0] t_addr [0:N-1];
    logic              t_busy [0:N-1];
    logic              t_done [0:N-1];

    int total = 0;
    int bad = 0;

    auto_player #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOTE_W(NOTE_W),
        .DUR_W(DUR_W), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .pause(pause), .loop_en(loop_en), .tempo_sel(tempo_sel),
        .note_value(note_value), .duration_value(duration_value),
        .mem_addr(mem_addr), .key_on(key_on), .key(key),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        note_value     <= mem_note[mem_addr];
        duration_value <= mem_dur[mem_addr];
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic load(input int n0, d0, n1, d1, n2, d2, n3, d3);
        mem_note[0] = NOTE_W'(n0); mem_dur[0] = DUR_W'(d0);
        mem_note[1] = NOTE_W'(n1); mem_dur[1] = DUR_W'(d1);
        mem_note[2] = NOTE_W'(n2); mem_dur[2] = DUR_W'(d2);
        mem_note[3] = NOTE_W'(n3); mem_dur[3] = DUR_W'(d3);
    endtask

    // sample i is taken on the falling edge after the i-th rising edge past start
    task automatic run(input int p_on, p_off, stop_at, both_at);
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            t_kon[i]  = key_on;
            t_key[i]  = key;
            t_addr[i] = mem_addr;
            t_busy[i] = busy;
            t_done[i] = done;
            pause = (i >= p_on && i < p_off);
            if (i == stop_at) stop = 1'b1;
            if (i == both_at) begin
                start = 1'b1;
                stop  = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    function automatic int kon_count(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) c += int'(t_kon[i]);
        return c;
    endfunction

    function automatic int done_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(t_done[i]);
        return c;
    endfunction

    logic [31:0] exp_kon;
    int max_addr;

    initial begin
        load(5, 4, 0, 2, 7, 1, 3, 2);
        repeat (3) @(negedge clk);
        check("rst_key_on", key_on, 0);
        check("rst_key", key, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        // one-shot song with a rest
        run(N, N, N, N);
        exp_kon = 32'h0304_003C;
        for (int i = 0; i < 32; i++) begin
            check($sformatf("s1_kon%0d", i), t_kon[i], exp_kon[i]);
        end
        check("s1_fetch_busy", t_busy[0], 1);
        check("s1_key5", t_key[2], 5);
        check("s1_key5_end", t_key[5], 5);
        check("s1_gap_key", t_key[7], 5);
        check("s1_rest_key", t_key[11], 0);
        check("s1_key7", t_key[18], 7);
        check("s1_key3a", t_key[24], 3);
        check("s1_key3b", t_key[25], 3);
        check("s1_addr1", t_addr[9], 1);
        check("s1_addr3", t_addr[22], 3);
        check("s1_busy28", t_busy[28], 1);
        check("s1_busy29", t_busy[29], 0);
        check("s1_done29", t_done[29], 1);
        check("s1_done_cnt", done_count(), 1);

        // looping
        loop_en = 1'b1;
        run(N, N, N, N);
        check("s2_addr3", t_addr[28], 3);
        check("s2_addr_wrap", t_addr[29], 0);
        check("s2_busy", t_busy[29], 1);
        check("s2_kon", t_kon[31], 1);
        check("s2_key", t_key[31], 5);
        check("s2_done_cnt", done_count(), 0);
        loop_en = 1'b0;

        // end marker at address 1
        load(4, 5, 6, 0, 0, 0, 0, 0);
        run(N, N, N, N);
        max_addr = 0;
        for (int i = 0; i < N; i++) begin
            if (int'(t_addr[i]) > max_addr) max_addr = int'(t_addr[i]);
        end
        check("s3_kon_cnt", kon_count(0, N - 1), 5);
        check("s3_busy11", t_busy[11], 1);
        check("s3_busy12", t_busy[12], 0);
        check("s3_done12", t_done[12], 1);
        check("s3_done_cnt", done_count(), 1);
        check("s3_max_addr", max_addr, 1);

        // pause during the third cycle of a 5-cycle note
        load(5, 5, 0, 0, 0, 0, 0, 0);
        run(4, 14, N, N);
        check("s4_kon_pre", kon_count(2, 4), 3);
        check("s4_kon_paused", kon_count(5, 14), 0);
        check("s4_key_paused", t_key[10], 5);
        check("s4_kon15", t_kon[15], 1);
        check("s4_kon16", t_kon[16], 1);
        check("s4_kon17", t_kon[17], 0);
        check("s4_kon_cnt", kon_count(0, N - 1), 5);

        // stop mid gap, then start and stop together
        load(5, 4, 0, 2, 7, 1, 3, 2);
        run(N, N, 7, 10);
        check("s5_busy7", t_busy[7], 1);
        check("s5_busy8", t_busy[8], 0);
        check("s5_key8", t_key[8], 0);
        check("s5_addr8", t_addr[8], 0);
        check("s5_busy11", t_busy[11], 0);
        check("s5_kon11", t_kon[11], 0);
        check("s5_busy12", t_busy[12], 0);
        check("s5_done_cnt", done_count(), 0);

        // tempo scaling
        load(2, 3, 0, 0, 0, 0, 0, 0);
        tempo_sel = 2'b11;
        run(N, N, N, N);
`ifdef AUTO_PLAYER_TEMPO_EN
        check("s6_div4", kon_count(0, N - 1), 1);
`else
        check("s6_div4", kon_count(0, N - 1), 3);
`endif
        tempo_sel = 2'b01;
        run(N, N, N, N);
`ifdef AUTO_PLAYER_TEMPO_EN
        check("s6_mul2", kon_count(0, N - 1), 6);
`else
        check("s6_mul2", kon_count(0, N - 1), 3);
`endif
        check("s6_first_kon", t_kon[2], 1);
        tempo_sel = 2'b00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
